// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Constants, opcode field position and state type shared by the
//             fetch stage and the decode stage that consumes its output.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int ADDR_W  = 5;
   localparam int INSTR_W = 19;

   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   // Opcode field occupies the top five bits of every instruction
   localparam int OPC_HI = 18;
   localparam int OPC_LO = 14;

   localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE = 5'b11111;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[OPC_HI:OPC_LO] == HALT_OPCODE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer_if
//  Purpose  : ROM, control-flow and decode-side signals of the fetch stage.
//             master = fetch stage, slave = ROM / control / decode side.
//             FETCH_PERF_EN adds the performance counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_instr;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_target;
   logic               resume;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               halted;
`ifdef FETCH_PERF_EN
   logic [15:0]        stall_cycles;
   logic [15:0]        fetch_count;
`endif

   modport master (
      output rom_addr, out_valid, out_instr, out_pc, halted,
`ifdef FETCH_PERF_EN
      output stall_cycles, fetch_count,
`endif
      input  rom_instr, redirect_valid, redirect_target, resume, out_ready
   );

   modport slave (
      input  rom_addr, out_valid, out_instr, out_pc, halted,
`ifdef FETCH_PERF_EN
      input  stall_cycles, fetch_count,
`endif
      output rom_instr, redirect_valid, redirect_target, resume, out_ready
   );

endinterface
`default_nettype wire

// File: rtl/fetch_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_reg
//  Purpose  : One-entry valid/ready holding register between ROM and decode.
//             Flush discards the held entry; a load refills it; a transfer
//             with no refill empties it.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_reg
   import fetch_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               load,
   input  wire logic               flush,
   input  wire logic [INSTR_W-1:0] load_instr,
   input  wire logic [ADDR_W-1:0]  load_pc,
   input  wire logic               out_ready,
   output      logic               out_valid,
   output      logic [INSTR_W-1:0] out_instr,
   output      logic [ADDR_W-1:0]  out_pc
);

   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc;

   // Flush beats load; an accepted entry empties unless refilled the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_instr <= load_instr;
         r_pc    <= load_pc;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_instr = r_instr;
   assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Program counter and RUN/HALT control for the fetch stage in
//             front of the 32-entry instruction ROM. Redirects override
//             everything; a fetched halt opcode parks the stage until resume.
//             Build option FETCH_PERF_EN adds saturating stall/fetch counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         rst_n,
   fetch_sequencer_if.master bus
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic              w_load;

   // A new instruction is captured only in RUN, when the holding register
   // frees up this cycle, and never alongside a redirect.
   assign w_load = (r_state == RUN) && (!bus.out_valid || bus.out_ready) &&
                   !bus.redirect_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_next;
   end

   // Next state: redirect forces RUN, halt opcode parks, resume releases
   always_comb begin
      w_state_next = r_state;
      if (bus.redirect_valid) begin
         w_state_next = RUN;
      end else if (r_state == RUN) begin
         if (w_load && is_halt(bus.rom_instr)) w_state_next = HALT;
      end else if (bus.resume) begin
         w_state_next = RUN;
      end
   end

   // Program counter: redirect target, else advance (mod 32) on each load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_pc <= RESET_PC;
      else if (bus.redirect_valid) r_pc <= bus.redirect_target;
      else if (w_load)             r_pc <= r_pc + ADDR_W'(1);
   end

   fetch_reg u_fetch_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_load),
      .flush      (bus.redirect_valid),
      .load_instr (bus.rom_instr),
      .load_pc    (r_pc),
      .out_ready  (bus.out_ready),
      .out_valid  (bus.out_valid),
      .out_instr  (bus.out_instr),
      .out_pc     (bus.out_pc)
   );

   assign bus.rom_addr = r_pc;
   assign bus.halted   = (r_state == HALT);

`ifdef FETCH_PERF_EN
   logic [15:0] r_stall_cycles;
   logic [15:0] r_fetch_count;

   // Saturating counts of decode back-pressure cycles and ROM captures
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_fetch_count  <= '0;
      end else begin
         if (bus.out_valid && !bus.out_ready && r_stall_cycles != 16'hFFFF)
            r_stall_cycles <= r_stall_cycles + 16'd1;
         if (w_load && r_fetch_count != 16'hFFFF)
            r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign bus.stall_cycles = r_stall_cycles;
   assign bus.fetch_count  = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed scenarios for fetch_sequencer against a small ROM
//             table: sequencing, stall, redirect, halt/resume, wrap, reset.
//             FETCH_PERF_EN also checks the performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   failed;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ROM image: address 5 carries the halt opcode, everything else opcode 0
   function automatic logic [INSTR_W-1:0] rom_val(input int a);
      if (a == 5) return {5'b11111, 14'd5};
      return INSTR_W'(a * 7 + 3);
   endfunction

   assign bus.rom_instr = rom_val(int'(bus.rom_addr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = '0;
      bus.resume = 1'b0;
      tick(); tick();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_instr !== '0 || bus.out_pc !== '0) begin
         failed++;
         $display("FAIL reset_outputs: got valid=%b instr=%h pc=%0d expected 0/0/0",
                  bus.out_valid, bus.out_instr, bus.out_pc);
      end
      tests_run++;
      if (bus.halted !== 1'b0 || bus.rom_addr !== 5'd0) begin
         failed++;
         $display("FAIL reset_pc_halt: got halted=%b rom_addr=%0d expected 0/0",
                  bus.halted, bus.rom_addr);
      end
      rst_n = 1'b1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         failed++;
         $display("FAIL release_no_valid: got %b expected 0", bus.out_valid);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd0 || bus.out_instr !== rom_val(0)) begin
         failed++;
         $display("FAIL first_fetch: got valid=%b pc=%0d instr=%h expected 1/0/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, rom_val(0));
      end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'(i) || bus.out_instr !== rom_val(i) ||
             bus.rom_addr !== 5'(i + 1)) begin
            failed++;
            $display("FAIL seq_%0d: got valid=%b pc=%0d instr=%h addr=%0d expected 1/%0d/%h/%0d",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr, i, rom_val(i), i + 1);
         end
      end
   endtask

   task automatic test_stall();
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd2;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd2 || bus.out_instr !== rom_val(2) ||
             bus.rom_addr !== 5'd3) begin
            failed++;
            $display("FAIL stall_hold_%0d: got valid=%b pc=%0d instr=%h addr=%0d expected 1/2/%h/3",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr, rom_val(2));
         end
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (bus.stall_cycles !== 16'd3 || bus.fetch_count !== 16'd5) begin
         failed++;
         $display("FAIL perf_after_stall: got stall=%0d fetch=%0d expected 3/5",
                  bus.stall_cycles, bus.fetch_count);
      end
`endif
   endtask

   task automatic test_redirect();
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd20;
      tick();
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.rom_addr !== 5'd20) begin
         failed++;
         $display("FAIL redirect_flush: got valid=%b addr=%0d expected 0/20", bus.out_valid, bus.rom_addr);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd20 || bus.out_instr !== rom_val(20)) begin
         failed++;
         $display("FAIL redirect_fetch: got valid=%b pc=%0d instr=%h expected 1/20/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, rom_val(20));
      end
   endtask

   task automatic test_halt();
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd3;
      tick();
      bus.redirect_valid = 1'b0;
      tick(); tick(); tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd5 || bus.out_instr !== rom_val(5) ||
          bus.halted !== 1'b1 || bus.rom_addr !== 5'd6) begin
         failed++;
         $display("FAIL halt_delivered: got valid=%b pc=%0d instr=%h halted=%b addr=%0d expected 1/5/%h/1/6",
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.halted, bus.rom_addr, rom_val(5));
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1) begin
         failed++;
         $display("FAIL halt_drained: got valid=%b halted=%b expected 0/1", bus.out_valid, bus.halted);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (bus.rom_addr !== 5'd6 || bus.out_valid !== 1'b0 || bus.halted !== 1'b1) begin
            failed++;
            $display("FAIL halt_hold_%0d: got addr=%0d valid=%b halted=%b expected 6/0/1",
                     i, bus.rom_addr, bus.out_valid, bus.halted);
         end
      end
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      tests_run++;
      if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0 || bus.rom_addr !== 5'd6) begin
         failed++;
         $display("FAIL resume_state: got halted=%b valid=%b addr=%0d expected 0/0/6",
                  bus.halted, bus.out_valid, bus.rom_addr);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd6 || bus.out_instr !== rom_val(6)) begin
         failed++;
         $display("FAIL resume_fetch: got valid=%b pc=%0d instr=%h expected 1/6/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, rom_val(6));
      end
   endtask

   task automatic test_resume_in_run();
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      tests_run++;
      if (bus.halted !== 1'b0 || bus.out_pc !== 5'd7 || bus.out_valid !== 1'b1) begin
         failed++;
         $display("FAIL resume_in_run: got halted=%b pc=%0d valid=%b expected 0/7/1",
                  bus.halted, bus.out_pc, bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_pc [4];
      exp_pc = '{5'd30, 5'd31, 5'd0, 5'd1};
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd30;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] ||
             bus.out_instr !== rom_val(int'(exp_pc[i]))) begin
            failed++;
            $display("FAIL wrap_%0d: got valid=%b pc=%0d instr=%h expected 1/%0d/%h",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i], rom_val(int'(exp_pc[i])));
         end
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (bus.stall_cycles !== 16'd4 || bus.fetch_count !== 16'd15) begin
         failed++;
         $display("FAIL perf_after_wrap: got stall=%0d fetch=%0d expected 4/15",
                  bus.stall_cycles, bus.fetch_count);
      end
`endif
   endtask

   task automatic test_redirect_resume();
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd5;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.halted !== 1'b1 || bus.out_pc !== 5'd5) begin
         failed++;
         $display("FAIL rr_setup: got halted=%b pc=%0d expected 1/5", bus.halted, bus.out_pc);
      end
      bus.redirect_valid = 1'b1; bus.redirect_target = 5'd9; bus.resume = 1'b1;
      tick();
      bus.redirect_valid = 1'b0; bus.resume = 1'b0;
      tests_run++;
      if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0 || bus.rom_addr !== 5'd9) begin
         failed++;
         $display("FAIL rr_state: got halted=%b valid=%b addr=%0d expected 0/0/9",
                  bus.halted, bus.out_valid, bus.rom_addr);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd9 || bus.out_instr !== rom_val(9)) begin
         failed++;
         $display("FAIL rr_fetch: got valid=%b pc=%0d instr=%h expected 1/9/%h",
                  bus.out_valid, bus.out_pc, bus.out_instr, rom_val(9));
      end
   endtask

   task automatic test_async_reset();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.out_instr !== '0 ||
          bus.rom_addr !== 5'd0 || bus.halted !== 1'b0) begin
         failed++;
         $display("FAIL async_reset: got valid=%b pc=%0d instr=%h addr=%0d halted=%b expected 0/0/0/0/0",
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr, bus.halted);
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (bus.stall_cycles !== 16'd0 || bus.fetch_count !== 16'd0) begin
         failed++;
         $display("FAIL perf_reset: got stall=%0d fetch=%0d expected 0/0",
                  bus.stall_cycles, bus.fetch_count);
      end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 5'd0) begin
         failed++;
         $display("FAIL post_reset_fetch: got valid=%b pc=%0d expected 1/0", bus.out_valid, bus.out_pc);
      end
   endtask

   initial begin
      tests_run = 0;
      failed    = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_halt();
      test_resume_in_run();
      test_wrap();
      test_redirect_resume();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch stage that sits directly upstream of the 32x19 instruction ROM.
- Drives the ROM address, captures the returned instruction into a one-entry fetch register, and presents it to decode with a valid/ready handshake.
- Handles control-flow redirects, halt detection and resume.
- Turns the single-cycle datapath's fetch into a stallable stage.

Parameters:
- ADDR_W, 5, instruction address width; 32 entries; PC wraps modulo 2^ADDR_W.
- INSTR_W, 19, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 5'b11111, value of instr[18:14] that marks a halt instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_W  address to the instruction ROM; equals pc combinationally.
- rom_instr  in  INSTR_W  ROM data; combinational from rom_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_target  in  ADDR_W  new PC when redirect_valid is high.
- resume  in  1  leave HALT; single-cycle pulse.
- out_valid  out  1  fetch register holds an instruction for decode.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  INSTR_W  fetched instruction.
- out_pc  out  ADDR_W  address out_instr was fetched from.
- halted  out  1  high while the state is HALT.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Reset mid-operation discards any held instruction immediately.
- States: RUN, HALT.
- Handshake: a transfer occurs in a cycle where out_valid && out_ready. out_instr and out_pc hold stable while out_valid=1 and out_ready=0.
- RUN, load condition (!out_valid || out_ready), when no redirect:
  - out_instr<=rom_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
  - The PC increment wraps 31->0 with no flag.
  - Latency: an instruction is visible at decode one cycle after its address is driven.
  - Back-to-back throughput is 1 instruction per cycle while out_ready=1.
- RUN, no load: pc and fetch register hold.
- Halt detection:
  - If rom_instr[18:14]==HALT_OPCODE on a load, the halt instruction itself is loaded normally and state<=HALT.
  - pc points to the next address.
- HALT:
  - No loads.
  - A pending instruction (including the halt) still drains: out_valid<=0 after its transfer.
  - halted=1.
  - resume: state<=RUN next cycle; fetch continues from the current pc.
  - resume while in RUN is ignored.
- Redirect (highest priority, any state):
  - pc<=redirect_target, out_valid<=0 (flushes the pending instruction), state<=RUN.
  - No ROM capture that cycle.
  - A transfer that completes in the same cycle counts as consumed by decode.
  - redirect + resume in the same cycle: redirect wins; result RUN.
  - Redirect when the target is the current pc: refetch, still flushed.
- Single-cycle pulse rule for redirect_valid and resume: each cycle high is acted on independently; no edge detection.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output stall_cycles [15:0]: saturating count of cycles with out_valid=1 and out_ready=0.
  - Adds output fetch_count [15:0]: saturating count of loads.
  - Both clear on reset.
  - Both saturate at 16'hFFFF; no wrap.
- Undefined: neither port nor any counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: ADDR_W, INSTR_W, RESET_PC, HALT_OPCODE, opcode field position [18:14], state enum {RUN, HALT}.
- Decode will import the same package.
- One natural sub-module: fetch_reg, the one-entry valid/ready holding register with flush input.
- PC and state machine stay in fetch_sequencer.

Test Plan:
- Reset then out_ready=1, ROM entries 0..3 non-halt:
  - out_pc sequence 0,1,2,3 on consecutive cycles.
  - First out_valid one cycle after rst_n rises.
- out_ready=0 for 3 cycles at out_pc=2:
  - out_instr/out_pc hold at entry 2.
  - pc stays 3.
  - With FETCH_PERF_EN, stall_cycles=3.
- Redirect to 20 while out_valid=1, out_ready=0:
  - Next cycle out_valid=0, rom_addr=20.
  - Following cycle out_pc=20.
- Halt opcode at address 5:
  - Instruction 5 is delivered, then halted=1 and out_valid=0.
  - pc=6 holds for 10 cycles.
  - resume -> out_pc=6 next fetch.
- pc=31 with out_ready=1:
  - out_pc 31 then 0, no stall.
- Same cycle redirect_valid (target 9) and resume while HALT:
  - State RUN, next out_pc=9.
- Assert rst_n low mid-stream:
  - out_valid drops immediately, without a clock edge.
